// File: rtl/nn_requant_act.sv
// nn_requant_act
//   Post-accumulation requantisation stage. Takes a wide signed MAC accumulator,
//   removes FRAC_BITS of fixed-point scaling with a round-half-up right shift,
//   applies the selected activation, then saturates to a DATA_WIDTH signed value.
//   Two-stage elastic pipeline with valid/ready on both sides.
//
//   Handshake: a beat moves across an interface on a rising clk edge where both
//   valid and ready are high. A producer holding valid keeps its data stable
//   until that edge. in_ready never depends on in_valid.
//
// Ports
//   clk        in   1            clock
//   rst_n      in   1            asynchronous active-low reset
//   in_valid   in   1            in_acc/in_mode valid
//   in_ready   out  1            stage accepts input this cycle
//   in_acc     in   ACCUM_WIDTH  signed accumulator value
//   in_mode    in   2            0/3 = bypass, 1 = ReLU, 2 = leaky ReLU (neg >>> 3)
//   out_valid  out  1            out_data valid
//   out_ready  in   1            downstream accepts out_data
//   out_data   out  DATA_WIDTH   signed activation
//   sat_clear  in   1            synchronous clear of sat_count
//   sat_count  out  CNT_WIDTH    number of clipped results, sticks at all-ones
module nn_requant_act #(
  parameter int DATA_WIDTH  = 8,
  parameter int ACCUM_WIDTH = 32,
  parameter int FRAC_BITS   = 8,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic signed [ACCUM_WIDTH-1:0] in_acc,
  input  logic        [1:0]             in_mode,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic signed [DATA_WIDTH-1:0]  out_data,
  input  logic                          sat_clear,
  output logic        [CNT_WIDTH-1:0]   sat_count
);

  // One extra bit so adding the rounding constant to the most positive
  // accumulator cannot wrap.
  localparam int AW1 = ACCUM_WIDTH + 1;

  // Half an LSB of the shifted result; zero when there is no shift.
  localparam logic signed [AW1-1:0] RND   = AW1'((2 ** FRAC_BITS) >> 1);
  localparam logic signed [AW1-1:0] MAX_V = AW1'((1 << (DATA_WIDTH - 1)) - 1);
  localparam logic signed [AW1-1:0] MIN_V = ~MAX_V;

  logic                  s1_valid;
  logic signed [AW1-1:0] s1_data;

  logic                  s2_adv;
  logic                  s1_adv;

  logic signed [AW1-1:0] acc_ext;
  logic signed [AW1-1:0] rounded;
  logic signed [AW1-1:0] act;
  logic signed [AW1-1:0] clipped_val;
  logic                  clip_hit;

  assign s2_adv   = !out_valid || out_ready;
  assign s1_adv   = s1_valid && s2_adv;
  assign in_ready = !s1_valid || s2_adv;

  // Stage 1 datapath: round, shift, activate.
  always_comb begin
    acc_ext = {in_acc[ACCUM_WIDTH-1], in_acc};
    rounded = (acc_ext + RND) >>> FRAC_BITS;
    act     = rounded;
    case (in_mode)
      2'd1:    if (rounded < 0) act = '0;
      2'd2:    if (rounded < 0) act = rounded >>> 3;
      default: act = rounded;
    endcase
  end

  // Stage 2 datapath: saturate the registered stage-1 value.
  always_comb begin
    clip_hit    = 1'b0;
    clipped_val = s1_data;
    if (s1_data > MAX_V) begin
      clipped_val = MAX_V;
      clip_hit    = 1'b1;
    end else if (s1_data < MIN_V) begin
      clipped_val = MIN_V;
      clip_hit    = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
    end else if (in_valid && in_ready) begin
      s1_valid <= 1'b1;
      s1_data  <= act;
    end else if (s1_adv) begin
      s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (s1_adv) begin
      out_valid <= 1'b1;
      out_data  <= clipped_val[DATA_WIDTH-1:0];
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Clear wins over a same-cycle increment; the count sticks at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_count <= '0;
    end else if (sat_clear) begin
      sat_count <= '0;
    end else if (s1_adv && clip_hit && !(&sat_count)) begin
      sat_count <= sat_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_nn_requant_act.sv
module tb_nn_requant_act;

  localparam int DW  = 8;
  localparam int AW  = 32;
  localparam int FB  = 8;
  localparam int CW  = 4;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [AW-1:0] in_acc;
  logic [1:0]    in_mode;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          sat_clear;
  logic [CW-1:0] sat_count;

  nn_requant_act #(
    .DATA_WIDTH(DW), .ACCUM_WIDTH(AW), .FRAC_BITS(FB), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_acc(in_acc), .in_mode(in_mode),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .sat_clear(sat_clear), .sat_count(sat_count)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [DW-1:0] exp_q[$];
  int            n_checks = 0;
  int            n_fail   = 0;
  int            sat_model = 0;
  int            ready_mode = 0;  // 0: always ready, 1: random, 2: stalled

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic longint floor_div(input longint a, input longint b);
    longint q;
    q = a / b;
    if ((a % b != 0) && (a < 0)) q = q - 1;
    return q;
  endfunction

  // Reference: round-half-up division by 2^FB, activation, then clamp.
  function automatic logic [DW-1:0] ref_act(input logic [AW-1:0] acc,
                                            input logic [1:0] m,
                                            output bit clipped);
    longint a, r;
    a = longint'($signed(acc));
    r = floor_div(a + (1 << (FB - 1)), longint'(1) << FB);
    if (m == 2'd1 && r < 0) r = 0;
    else if (m == 2'd2 && r < 0) r = floor_div(r, 8);
    clipped = (r > 127) || (r < -128);
    if (r > 127) r = 127;
    if (r < -128) r = -128;
    return DW'(r);
  endfunction

  // ---------------- driver tasks ----------------
  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [AW-1:0] acc, input logic [1:0] m);
    bit c;
    logic [DW-1:0] e;
    in_valid = 1'b1;
    in_acc   = acc;
    in_mode  = m;
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      if (in_ready) begin
        e = ref_act(acc, m, c);
        exp_q.push_back(e);
        if (c && sat_model < CNT_MAX) sat_model++;
        @(posedge clk); #1;
        in_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    n_checks++;
    n_fail++;
    $display("FAIL send_timeout: in_ready stayed 0 for acc %h", acc);
    in_valid = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 1000) begin
      cycles(1);
      t++;
    end
    check("drain_empty", exp_q.size(), 0);
    cycles(2);
  endtask

  // ---------------- out_ready generator ----------------
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = ($urandom_range(0, 9) < 7);
      default: out_ready = 1'b0;
    endcase
  end

  // ---------------- monitor ----------------
  bit            hold;
  logic [DW-1:0] hold_data;

  always @(negedge clk) begin
    logic [DW-1:0] e;
    if (!rst_n) begin
      hold = 1'b0;
    end else begin
      if (hold) begin
        check("hold_valid", out_valid, 1);
        check("hold_data", $signed(out_data), $signed(hold_data));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out", $signed(out_data), 999);
        end else begin
          e = exp_q.pop_front();
          check("out_data", $signed(out_data), $signed(e));
        end
      end
      hold      = out_valid && !out_ready;
      hold_data = out_data;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_acc    = '0;
    in_mode   = '0;
    out_ready = 1'b1;
    sat_clear = 1'b0;
    #23;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_sat_count", sat_count, 0);
    rst_n = 1'b1;
    cycles(2);

    // Rounding and latency
    send(32'h0000_0280, 2'd0);
    @(negedge clk);
    check("lat_cycle1_valid", out_valid, 0);
    @(negedge clk);
    check("lat_cycle2_valid", out_valid, 1);
    @(posedge clk); #1;
    send(32'hFFFF_FD80, 2'd0);
    send(32'h0000_017F, 2'd0);
    drain();

    // ReLU and saturation
    send(-32'sh500, 2'd1);
    send(32'h0000_7F00, 2'd1);
    send(32'h0000_8000, 2'd1);
    drain();
    check("sat_after_first_clip", sat_count, 1);
    send(-32'sh9000, 2'd0);
    drain();
    check("sat_after_second_clip", sat_count, 2);
    send(32'h7FFF_FFFF, 2'd0);
    drain();
    check("sat_model_match", sat_count, sat_model);

    // Leaky ReLU with modes changing every beat
    send(-32'sh4000, 2'd2);
    send(-32'sh10000, 2'd0);
    send(-32'sh10000, 2'd2);
    send(32'h0000_0500, 2'd2);
    send(-32'sh4000, 2'd1);
    send(-32'sh4000, 2'd3);
    drain();

    // Backpressure: two items buffered, then stall
    ready_mode = 2;
    cycles(1);
    send(32'h0000_0100, 2'd0);
    send(32'h0000_0200, 2'd0);
    in_valid = 1'b1;
    in_acc   = 32'h0000_0300;
    in_mode  = 2'd0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_in_ready_low", in_ready, 0);
      @(posedge clk); #1;
    end
    ready_mode = 0;
    send(32'h0000_0300, 2'd0);
    drain();

    // Random stream with random backpressure
    ready_mode = 1;
    for (int i = 0; i < 300; i++) begin
      logic [AW-1:0] a;
      case ($urandom_range(0, 3))
        0:       a = $urandom;
        1:       a = AW'($urandom_range(0, 32'h2_0000)) - 32'h1_0000;
        2:       a = AW'($urandom_range(0, 32'h1000)) + 32'h7800;
        default: a = 32'hFFFF_8000 - AW'($urandom_range(0, 32'h1000)) + 32'h800;
      endcase
      send(a, 2'($urandom_range(0, 3)));
      if ($urandom_range(0, 3) == 0) cycles($urandom_range(1, 3));
    end
    ready_mode = 0;
    drain();
    check("sat_random_model", sat_count, sat_model);

    // Counter saturation and clear priority
    sat_clear = 1'b1;
    cycles(1);
    sat_clear = 1'b0;
    sat_model = 0;
    check("sat_cleared", sat_count, 0);
    for (int i = 0; i < CNT_MAX + 5; i++) send(32'h0010_0000, 2'd0);
    drain();
    check("sat_sticky_all_ones", sat_count, CNT_MAX);
    send(32'h0010_0000, 2'd0);
    sat_clear = 1'b1;  // covers the edge where this clipped item advances
    cycles(1);
    sat_clear = 1'b0;
    sat_model = 0;
    drain();
    check("sat_clear_priority", sat_count, 0);

    // Reset mid-stream with two items buffered
    ready_mode = 2;
    cycles(1);
    send(32'h0000_0400, 2'd0);
    send(32'h0000_0500, 2'd0);
    cycles(1);
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_in_ready", in_ready, 1);
    exp_q.delete();
    sat_model = 0;
    cycles(2);
    rst_n = 1'b1;
    ready_mode = 0;
    cycles(5);
    check("post_rst_out_valid", out_valid, 0);
    send(32'h0000_0600, 2'd0);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1);
  end

endmodule
